// File: rtl/bp_ghr_ckpt_if.sv
// Frontend/execute <-> GHR checkpoint manager handshake bundle.
// Latency: none; plain wires, timing is owned by bp_ghr_ckpt.
// Backpressure: the frontend stalls while ckpt_ready_o is low.
// Signals: spec_* push predicted branches; ckpt_* report the free slot and tag;
//          resolve_* retire the oldest branch; ghr_o / ghr_commit_o are the histories.
interface bp_ghr_ckpt_if #(
   parameter int unsigned GHR_BITS = 10,
   parameter int unsigned NR_CKPT  = 8
);
   localparam int unsigned IdW = $clog2(NR_CKPT);

   logic                spec_valid_i;
   logic                spec_taken_i;
   logic                ckpt_ready_o;
   logic [IdW-1:0]      ckpt_id_o;
   logic                resolve_valid_i;
   logic [IdW-1:0]      resolve_id_i;
   logic                resolve_mispredict_i;
   logic                resolve_taken_i;
   logic [GHR_BITS-1:0] ghr_o;
   logic [GHR_BITS-1:0] ghr_commit_o;

   // Frontend / execute side.
   modport master (
      output spec_valid_i, spec_taken_i,
      output resolve_valid_i, resolve_id_i, resolve_mispredict_i, resolve_taken_i,
      input  ckpt_ready_o, ckpt_id_o, ghr_o, ghr_commit_o
   );

   // History manager side.
   modport slave (
      input  spec_valid_i, spec_taken_i,
      input  resolve_valid_i, resolve_id_i, resolve_mispredict_i, resolve_taken_i,
      output ckpt_ready_o, ckpt_id_o, ghr_o, ghr_commit_o
   );
endinterface

// File: rtl/bp_ghr_ckpt.sv
// Speculative gshare global-history register with per-branch checkpoints for 1-cycle recovery.
// Latency: push/resolve visible on ghr_o / ghr_commit_o one cycle later; ckpt_ready_o/ckpt_id_o combinational.
// Backpressure: ckpt_ready_o low when all checkpoints are in flight (unless a correct resolve frees one this cycle).
// Ports: clk_i, rst_ni (async active-low), flush_bp_i clears all state, debug_mode_i freezes
//        the committed history, bus carries the push/resolve handshake, err_o is a sticky
//        out-of-order / empty resolve flag.
module bp_ghr_ckpt #(
   parameter bit          DebugEn  = 1'b0,
   parameter int unsigned GHR_BITS = 10,
   parameter int unsigned NR_CKPT  = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_bp_i,
   input  logic          debug_mode_i,
   bp_ghr_ckpt_if.slave  bus,
   output logic          err_o
);
   localparam int unsigned IdW  = $clog2(NR_CKPT);
   localparam int unsigned CntW = IdW + 1;

   logic [GHR_BITS-1:0] ghr_spec_q;
   logic [GHR_BITS-1:0] ghr_commit_q;
   logic [IdW-1:0]      head_q;
   logic [IdW-1:0]      tail_q;
   logic [CntW-1:0]     count_q;
   logic                err_q;

   // The MSB of a checkpointed history is shifted out on restore, so it is never stored.
   logic [GHR_BITS-2:0] ckpt_q [NR_CKPT];

   logic id_match;
   logic res_ok;
   logic res_bad;
   logic mispred;
   logic ckpt_ready;
   logic push;
   logic commit_en;

   always_comb begin
      id_match   = (bus.resolve_id_i == head_q) && (count_q != '0);
      res_ok     = bus.resolve_valid_i && id_match;
      res_bad    = bus.resolve_valid_i && !id_match;
      mispred    = res_ok && bus.resolve_mispredict_i;
      // A correct resolve frees a slot in the same cycle, so a full buffer can still accept.
      ckpt_ready = (count_q < CntW'(NR_CKPT)) || (res_ok && !bus.resolve_mispredict_i);
      // The frontend is being redirected on a mispredict, so its push is stale.
      push       = bus.spec_valid_i && ckpt_ready && !mispred;
      commit_en  = res_ok && !(DebugEn && debug_mode_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ghr_spec_q   <= '0;
         ghr_commit_q <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
      end else if (flush_bp_i) begin
         ghr_spec_q   <= '0;
         ghr_commit_q <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         if (res_bad) begin
            err_q <= 1'b1;
         end

         if (mispred) begin
            // Rebuild history from the branch's own checkpoint plus its real outcome,
            // and squash every younger checkpoint.
            ghr_spec_q <= {ckpt_q[head_q], bus.resolve_taken_i};
            head_q     <= head_q + IdW'(1);
            tail_q     <= head_q + IdW'(1);
            count_q    <= '0;
         end else begin
            if (push) begin
               ghr_spec_q <= {ghr_spec_q[GHR_BITS-2:0], bus.spec_taken_i};
               tail_q     <= tail_q + IdW'(1);
            end
            if (res_ok) begin
               head_q <= head_q + IdW'(1);
            end
            case ({push, res_ok})
               2'b10:   count_q <= count_q + CntW'(1);
               2'b01:   count_q <= count_q - CntW'(1);
               default: count_q <= count_q;
            endcase
         end

         if (commit_en) begin
            ghr_commit_q <= {ghr_commit_q[GHR_BITS-2:0], bus.resolve_taken_i};
         end
      end
   end

   // Checkpoint storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push) begin
         ckpt_q[tail_q] <= ghr_spec_q[GHR_BITS-2:0];
      end
   end

   assign bus.ckpt_ready_o = ckpt_ready;
   assign bus.ckpt_id_o    = tail_q;
   assign bus.ghr_o        = ghr_spec_q;
   assign bus.ghr_commit_o = ghr_commit_q;
   assign err_o            = err_q;
endmodule

// File: tb/tb_bp_ghr_ckpt.sv
// Directed bench for bp_ghr_ckpt with GHR_BITS=4, NR_CKPT=8, DebugEn=1.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Expected values are hand-derived from the history shift/restore rules.
module tb_bp_ghr_ckpt;
   localparam int unsigned G = 4;
   localparam int unsigned N = 8;

   logic clk_i        = 1'b0;
   logic rst_ni       = 1'b0;
   logic flush_bp_i   = 1'b0;
   logic debug_mode_i = 1'b0;
   logic err_o;

   int n_vec = 0;
   int n_err = 0;

   bp_ghr_ckpt_if #(.GHR_BITS(G), .NR_CKPT(N)) bus ();

   bp_ghr_ckpt #(.DebugEn(1'b1), .GHR_BITS(G), .NR_CKPT(N)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_bp_i   (flush_bp_i),
      .debug_mode_i (debug_mode_i),
      .bus          (bus),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.spec_valid_i         = 1'b0;
      bus.spec_taken_i         = 1'b0;
      bus.resolve_valid_i      = 1'b0;
      bus.resolve_id_i         = '0;
      bus.resolve_mispredict_i = 1'b0;
      bus.resolve_taken_i      = 1'b0;
      flush_bp_i               = 1'b0;
      debug_mode_i             = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic t);
      bus.spec_valid_i = 1'b1;
      bus.spec_taken_i = t;
   endtask

   task automatic resolve(input int id, input logic mis, input logic t);
      bus.resolve_valid_i      = 1'b1;
      bus.resolve_id_i         = 3'(id);
      bus.resolve_mispredict_i = mis;
      bus.resolve_taken_i      = t;
   endtask

   task automatic check_state(input string tag, input logic [3:0] ghr, input logic [3:0] cmt,
                              input int id, input logic rdy, input logic err);
      check({tag, ".ghr"},    32'(bus.ghr_o),        32'(ghr));
      check({tag, ".commit"}, 32'(bus.ghr_commit_o), 32'(cmt));
      check({tag, ".id"},     32'(bus.ckpt_id_o),    32'(id));
      check({tag, ".ready"},  32'(bus.ckpt_ready_o), 32'(rdy));
      check({tag, ".err"},    32'(err_o),            32'(err));
   endtask

   int dirs [8] = '{1, 0, 1, 1, 0, 0, 1, 0};

   initial begin
      idle();
      #2;
      check_state("reset", 4'b0000, 4'b0000, 0, 1'b1, 1'b0);
      tick();
      tick();
      rst_ni = 1'b1;

      // Basic pushes: taken, taken, not-taken.
      push(1'b1); #1 check("push0.id", 32'(bus.ckpt_id_o), 0); tick();
      push(1'b1); #1 check("push1.id", 32'(bus.ckpt_id_o), 1); tick();
      push(1'b0); #1 check("push2.id", 32'(bus.ckpt_id_o), 2); tick();
      idle();
      check_state("basic", 4'b0110, 4'b0000, 3, 1'b1, 1'b0);

      // Mispredict of id0, actual not-taken: restore to ckpt[0]=0000 shifted with 0.
      resolve(0, 1'b1, 1'b0); tick(); idle();
      check_state("mispred0", 4'b0000, 4'b0000, 1, 1'b1, 1'b0);

      // Fill all 8 slots starting at id1.
      for (int i = 0; i < 8; i++) begin
         push(dirs[i][0]);
         #1 check("fill.id", 32'(bus.ckpt_id_o), 32'((1 + i) % 8));
         tick();
      end
      idle(); #1;
      check_state("full", 4'b0010, 4'b0000, 1, 1'b0, 1'b0);

      // Ninth push alone is ignored.
      push(1'b1); #1 check("full_push.ready", 32'(bus.ckpt_ready_o), 0);
      tick(); idle();
      check_state("full_ign", 4'b0010, 4'b0000, 1, 1'b0, 1'b0);

      // Ninth push with correct resolve of the head (id1, taken) is accepted.
      push(1'b1); resolve(1, 1'b0, 1'b1);
      #1 check("full_swap.ready", 32'(bus.ckpt_ready_o), 1);
      tick(); idle();
      check_state("full_swap", 4'b0101, 4'b0001, 2, 1'b0, 1'b0);

      // Correct resolve of id2 (not taken) frees one slot.
      resolve(2, 1'b0, 1'b0); tick(); idle();
      check_state("res2", 4'b0101, 4'b0010, 2, 1'b1, 1'b0);

      // Mispredict of id3 with a concurrent push: ckpt[3]=0010 -> 0100, push dropped.
      push(1'b1); resolve(3, 1'b1, 1'b0); tick(); idle();
      check_state("mispred3", 4'b0100, 4'b0100, 4, 1'b1, 1'b0);

      // Resolve with nothing outstanding.
      resolve(4, 1'b0, 1'b1); tick(); idle();
      check_state("err_empty", 4'b0100, 4'b0100, 4, 1'b1, 1'b1);
      tick();
      check("err_sticky", 32'(err_o), 1);
      flush_bp_i = 1'b1; tick(); idle();
      check_state("flush1", 4'b0000, 4'b0000, 0, 1'b1, 1'b0);

      // Resolve with the wrong tag: ignored, head stays at 0.
      push(1'b1); tick(); idle();
      resolve(1, 1'b0, 1'b1); tick(); idle();
      check_state("err_id", 4'b0001, 4'b0000, 1, 1'b1, 1'b1);
      resolve(0, 1'b0, 1'b1); tick(); idle();
      check("after_err.commit", 32'(bus.ghr_commit_o), 32'(4'b0001));
      flush_bp_i = 1'b1; tick(); idle();
      check_state("flush2", 4'b0000, 4'b0000, 0, 1'b1, 1'b0);

      // Flush beats a same-cycle push and mispredict.
      push(1'b1); tick(); push(1'b1); tick(); idle();
      check("pre_flush.ghr", 32'(bus.ghr_o), 32'(4'b0011));
      push(1'b1); resolve(0, 1'b1, 1'b1); flush_bp_i = 1'b1; tick(); idle();
      check_state("flush_prio", 4'b0000, 4'b0000, 0, 1'b1, 1'b0);

      // Debug-mode resolve frees the slot without touching the committed history.
      push(1'b1); tick(); push(1'b1); tick(); idle();
      debug_mode_i = 1'b1; resolve(0, 1'b0, 1'b1); tick(); idle();
      check_state("debug_res", 4'b0011, 4'b0000, 2, 1'b1, 1'b0);
      resolve(1, 1'b0, 1'b1); tick(); idle();
      check_state("post_debug", 4'b0011, 4'b0001, 2, 1'b1, 1'b0);

      // Wrap-around: 20 push/resolve pairs with alternating directions.
      for (int i = 0; i < 20; i++) begin
         push(1'(i % 2));
         #1 check("wrap.id", 32'(bus.ckpt_id_o), 32'((2 + i) % 8));
         tick(); idle();
         resolve((2 + i) % 8, 1'b0, 1'(i % 2));
         tick(); idle();
      end
      check_state("wrap", 4'b0101, 4'b0101, 6, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle with a checkpoint outstanding.
      push(1'b1); tick(); idle();
      check("pre_rst.ghr", 32'(bus.ghr_o), 32'(4'b1011));
      #2 rst_ni = 1'b0;
      #1 check_state("async_rst", 4'b0000, 4'b0000, 0, 1'b1, 1'b0);
      tick();
      rst_ni = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
